wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width (from defines).
REQ-002 SHALL have port: clk  in  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: mem_valid  in  1  memory-stage instruction offered.
REQ-005 SHALL have port: mem_ready  out  1  stage accepts offered instruction (combinational, state==IDLE).
REQ-006 SHALL have port: mem_rd_addr  in  5  destination register.
REQ-007 SHALL have port: mem_rd_wren  in  1  instruction writes rd.
REQ-008 SHALL have port: mem_is_load  in  1  instruction is a load.
REQ-009 SHALL have port: mem_funct3  in  3  load type.
REQ-010 SHALL have port: mem_addr_lo  in  2  load byte offset.
REQ-011 SHALL have port: mem_alu_data  in  XLEN  non-load result.
REQ-012 SHALL have port: dmem_rvalid  in  1  load word returned.
REQ-013 SHALL have port: dmem_rdata  in  XLEN  aligned load word.
REQ-014 SHALL have port: rd_wren  out  1  register-file write enable.
REQ-015 SHALL have port: rd_addr  out  5  register-file write address.
REQ-016 SHALL have port: rd_data  out  XLEN  register-file write data.
REQ-017 SHALL have port: retire  out  1  one-cycle pulse per completed instruction.
REQ-018 SHALL have port: load_err  out  1  one-cycle pulse on misaligned or illegal load.
REQ-019 SHALL have port: instret  out  64  retired-instruction count.

Function
REQ-020 SHALL implement states IDLE and WAIT_LOAD; mem_ready=1 only in IDLE.
REQ-021 SHALL accept an instruction on a clk edge where mem_valid && mem_ready.
REQ-022 Non-load accept SHALL, at that same edge, register rd_addr=mem_rd_addr, rd_data=mem_alu_data, rd_wren=mem_rd_wren && (mem_rd_addr!=0), retire=1; state stays IDLE; back-to-back throughput one per cycle.
REQ-023 Load accept SHALL capture rd_addr, rd_wren intent, funct3, addr_lo and move to WAIT_LOAD; rd_wren=0 and retire=0 that cycle.
REQ-024 dmem_rvalid SHALL be honoured only in WAIT_LOAD; in IDLE it is ignored.
REQ-025 On dmem_rvalid in WAIT_LOAD SHALL register the extracted value, rd_wren per REQ-022 rule, retire=1, return to IDLE; minimum load latency is two cycles from accept to rd_wren.
REQ-026 Extraction: LB 000 sign-extend byte [8*addr_lo+:8]; LH 001 sign-extend half [16*addr_lo[1]+:16]; LW 010 full word; LBU 100, LHU 101 zero-extend likewise.
REQ-027 LH/LHU with addr_lo[0]=1, LW with addr_lo!=0, or funct3 in {011,110,111} SHALL on dmem_rvalid pulse load_err=1, rd_wren=0, retire=0, return to IDLE.
REQ-028 Any write with rd_addr==0 SHALL produce rd_wren=0 (retire still pulses).
REQ-029 rd_wren, retire, load_err SHALL be single-cycle pulses; rd_addr/rd_data hold last value otherwise.
REQ-030 instret SHALL increment by 1 on each retire pulse edge, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-031 All outputs except mem_ready SHALL be registered.

Reset
REQ-032 On rst at a clk edge: state=IDLE, rd_wren=0, rd_addr=0, rd_data=0, retire=0, load_err=0, instret=0.
REQ-033 Reset in WAIT_LOAD SHALL drop the pending load: no write, no retire, later dmem_rvalid ignored.
REQ-034 rst SHALL take priority over any simultaneous accept or dmem_rvalid.

Verification
REQ-035 Non-load: mem_valid, rd=5, alu_data=0x1234_5678 -> next cycle rd_wren=1, rd_addr=5, rd_data=0x1234_5678, retire=1, instret=1.
REQ-036 LB addr_lo=3, dmem_rdata=0x80FF_0000, rvalid 3 cycles after accept -> rd_data=0xFFFF_FF80 one cycle after rvalid; mem_ready=0 while waiting.
REQ-037 LHU addr_lo=2, rdata=0xBEEF_0001 -> rd_data=0x0000_BEEF; LW addr_lo=1 -> load_err=1, rd_wren=0, instret unchanged.
REQ-038 Non-load rd=0 -> rd_wren=0, retire=1; 4 back-to-back non-loads -> 4 consecutive retire pulses.
REQ-039 rst asserted in WAIT_LOAD, rvalid next cycle -> no rd_wren, instret=0, mem_ready=1.
REQ-040 Preload-free wrap: 2^64-1 not reachable; bench forces instret=0xFFFF_FFFF_FFFF_FFFF via hierarchical deposit, one retire -> instret=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and extracts load data from the returned word.
// Latency: non-load 1 cycle from accept; load 1 cycle after dmem_rvalid (2 cycles minimum).
// Backpressure: mem_ready drops while a load is outstanding; dmem_rvalid outside WAIT_LOAD is ignored.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rd_wren,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_data,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            retire,
    output logic            load_err,
    output logic [63:0]     instret
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rd_wren;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } pend_t;

    state_t          state;
    pend_t           pend;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_val;
    logic            ld_bad;

    assign mem_ready = (state == IDLE);

    always_comb begin
        ld_byte = dmem_rdata[{pend.addr_lo, 3'b000} +: 8];
        ld_half = dmem_rdata[{pend.addr_lo[1], 4'b0000} +: 16];
        ld_val  = '0;
        ld_bad  = 1'b0;
        case (pend.funct3)
            3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001: begin
                ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
                ld_bad = pend.addr_lo[0];
            end
            3'b010: begin
                ld_val = dmem_rdata;
                ld_bad = |pend.addr_lo;
            end
            3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101: begin
                ld_val = {{(XLEN-16){1'b0}}, ld_half};
                ld_bad = pend.addr_lo[0];
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            rd_wren  <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            retire   <= 1'b0;
            load_err <= 1'b0;
            instret  <= '0;
        end else begin
            rd_wren  <= 1'b0;
            retire   <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid && mem_is_load) begin
                        pend  <= '{rd_addr: mem_rd_addr, rd_wren: mem_rd_wren,
                                   funct3: mem_funct3, addr_lo: mem_addr_lo};
                        state <= WAIT_LOAD;
                    end else if (mem_valid) begin
                        rd_addr <= mem_rd_addr;
                        rd_data <= mem_alu_data;
                        rd_wren <= mem_rd_wren && (mem_rd_addr != 5'd0);
                        retire  <= 1'b1;
                        instret <= instret + 64'd1;
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        state <= IDLE;
                        if (ld_bad) begin
                            load_err <= 1'b1;
                        end else begin
                            rd_addr <= pend.rd_addr;
                            rd_data <= ld_val;
                            rd_wren <= pend.rd_wren && (pend.rd_addr != 5'd0);
                            retire  <= 1'b1;
                            instret <= instret + 64'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
